// File: rtl/aesha_pkg.sv
// Shared definitions for the AESHA stream controller: default widths,
// derived word counts, command bit positions and FSM state encodings.
package aesha_pkg;

   localparam int AESHA_WORD_W = 32;
   localparam int AESHA_KEY_W  = 128;
   localparam int AESHA_DATA_W = 512;

   localparam int KEY_WORDS  = AESHA_KEY_W / AESHA_WORD_W;
   localparam int DATA_WORDS = AESHA_DATA_W / AESHA_WORD_W;

   localparam int CMD_MODE_BIT  = 0;
   localparam int CMD_DIR_BIT   = 1;
   localparam int CMD_REUSE_BIT = 2;

   typedef logic [2:0] aesha_state_t;

   localparam aesha_state_t S_CMD    = 3'd0;
   localparam aesha_state_t S_KEY    = 3'd1;
   localparam aesha_state_t S_DATA   = 3'd2;
   localparam aesha_state_t S_LAUNCH = 3'd3;
   localparam aesha_state_t S_WAIT   = 3'd4;
   localparam aesha_state_t S_DRAIN  = 3'd5;

endpackage

// File: rtl/aesha_word_pack.sv
// Word assembler: writes N stream words into a wide register, word 0 at the
// LSW, with a word counter and a last-word flag.
// Ports: i_clk, i_reset (async, high), i_clr (counter clear), i_we (write
// strobe), i_word (input word), o_value (assembled register), o_last.
module aesha_word_pack #(
   parameter int WORD_W = 32,
   parameter int N      = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_clr,
   input  logic                i_we,
   input  logic [WORD_W-1:0]   i_word,
   output logic [N*WORD_W-1:0] o_value,
   output logic                o_last
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [CW-1:0]       r_cnt;
   logic [N*WORD_W-1:0] r_value;

   assign o_last  = (r_cnt == CW'(N - 1));
   assign o_value = r_value;

   // The register keeps its contents between frames so a key can be reused.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt   <= '0;
         r_value <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_we) begin
         r_value[r_cnt*WORD_W +: WORD_W] <= i_word;
         r_cnt <= o_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/aesha_stream_ctrl.sv
// Stream initiator for the AESHA accelerator: assembles command/key/block from
// a 32-bit valid/ready stream, runs one core operation and streams the result.
// Ports: i_clk, i_reset (async, high); input stream i_in_data/i_in_valid/
// o_in_ready; output stream o_out_data/o_out_valid/i_out_ready; core side
// o_core_reset, o_core_aes_or_keccak, o_core_enc_or_dec, o_core_key,
// o_core_data, i_core_data, i_core_done; status o_busy, o_error.
// Optional watchdog: define AESHA_STREAM_TIMEOUT_EN.
module aesha_stream_ctrl
   import aesha_pkg::*;
#(
   parameter int WORD_W         = AESHA_WORD_W,
   parameter int KEY_W          = AESHA_KEY_W,
   parameter int DATA_W         = AESHA_DATA_W,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [WORD_W-1:0] i_in_data,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic [WORD_W-1:0] o_out_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_core_reset,
   output logic              o_core_aes_or_keccak,
   output logic              o_core_enc_or_dec,
   output logic [KEY_W-1:0]  o_core_key,
   output logic [DATA_W-1:0] o_core_data,
   input  logic [DATA_W-1:0] i_core_data,
   input  logic              i_core_done,
   output logic              o_busy,
   output logic              o_error
);

   localparam int KWORDS = KEY_W / WORD_W;
   localparam int DWORDS = DATA_W / WORD_W;
   localparam int IW     = (DWORDS > 1) ? $clog2(DWORDS) : 1;

   aesha_state_t      r_state;
   logic              r_mode;
   logic              r_dir;
   logic              r_core_rst;
   logic              r_rdy_en;
   logic [DATA_W-1:0] r_result;
   logic [IW-1:0]     r_out_idx;

   logic w_in_st;
   logic w_in_ready;
   logic w_in_fire;
   logic w_out_fire;
   logic w_key_last;
   logic w_data_last;
   logic w_out_last;
   logic w_timeout;

   assign w_in_st = (r_state == S_CMD) ||
                    (r_state == S_KEY) ||
                    (r_state == S_DATA);

   // r_rdy_en keeps ready low while reset is asserted and for the
   // reset-release cycle itself.
   assign w_in_ready = r_rdy_en & w_in_st;
   assign w_in_fire  = i_in_valid & w_in_ready;
   assign w_out_fire = (r_state == S_DRAIN) & i_out_ready;
   assign w_out_last = (r_out_idx == IW'(DWORDS - 1));

   aesha_word_pack #(
      .WORD_W (WORD_W),
      .N      (KWORDS)
   ) u_key_pack (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (r_state != S_KEY),
      .i_we    (w_in_fire & (r_state == S_KEY)),
      .i_word  (i_in_data),
      .o_value (o_core_key),
      .o_last  (w_key_last)
   );

   aesha_word_pack #(
      .WORD_W (WORD_W),
      .N      (DWORDS)
   ) u_data_pack (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (r_state != S_DATA),
      .i_we    (w_in_fire & (r_state == S_DATA)),
      .i_word  (i_in_data),
      .o_value (o_core_data),
      .o_last  (w_data_last)
   );

`ifdef AESHA_STREAM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [TW-1:0] r_tmo_cnt;
   logic          r_error;

   assign w_timeout = (r_state == S_WAIT) &&
                      (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_tmo_cnt <= '0;
         r_error   <= 1'b0;
      end else begin
         r_tmo_cnt <= (r_state == S_WAIT) ? r_tmo_cnt + 1'b1 : '0;
         if (w_timeout && !i_core_done)
            r_error <= 1'b1;
      end
   end

   assign o_error = r_error;
`else
   assign w_timeout = 1'b0;
   // Watchdog length has no effect in this build; expression is always 0.
   assign o_error   = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_CMD;
         r_mode     <= 1'b0;
         r_dir      <= 1'b0;
         r_core_rst <= 1'b1;
         r_rdy_en   <= 1'b0;
         r_result   <= '0;
         r_out_idx  <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         unique case (r_state)
            S_CMD: begin
               if (w_in_fire) begin
                  r_mode  <= i_in_data[CMD_MODE_BIT];
                  r_dir   <= i_in_data[CMD_DIR_BIT];
                  r_state <= i_in_data[CMD_REUSE_BIT] ? S_DATA : S_KEY;
               end
            end
            S_KEY: begin
               if (w_in_fire && w_key_last)
                  r_state <= S_DATA;
            end
            S_DATA: begin
               // Core leaves reset in the launch cycle itself.
               if (w_in_fire && w_data_last) begin
                  r_state    <= S_LAUNCH;
                  r_core_rst <= 1'b0;
               end
            end
            S_LAUNCH: begin
               // A done left over from a previous run is ignored here.
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (i_core_done) begin
                  r_result   <= i_core_data;
                  r_core_rst <= 1'b1;
                  r_state    <= S_DRAIN;
               end else if (w_timeout) begin
                  r_result   <= '0;
                  r_core_rst <= 1'b1;
                  r_state    <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_out_fire) begin
                  if (w_out_last) begin
                     r_out_idx <= '0;
                     r_state   <= S_CMD;
                  end else begin
                     r_out_idx <= r_out_idx + 1'b1;
                  end
               end
            end
            default: r_state <= S_CMD;
         endcase
      end
   end

   assign o_in_ready           = w_in_ready;
   assign o_out_valid          = (r_state == S_DRAIN);
   assign o_out_data           = (r_state == S_DRAIN) ?
                                 r_result[r_out_idx*WORD_W +: WORD_W] :
                                 '0;
   assign o_core_reset         = r_core_rst;
   assign o_core_aes_or_keccak = r_mode;
   assign o_core_enc_or_dec    = r_dir;
   assign o_busy               = (r_state != S_CMD);

endmodule

// File: tb/tb_aesha_stream_ctrl.sv
// Self-checking bench for aesha_stream_ctrl: directed frames with random
// data, input gaps and output backpressure against a behavioural core model.
module tb_aesha_stream_ctrl;

   localparam int TMO = 64;

   logic         clk = 1'b0;
   logic         i_reset;
   logic [31:0]  i_in_data;
   logic         i_in_valid;
   logic         o_in_ready;
   logic [31:0]  o_out_data;
   logic         o_out_valid;
   logic         i_out_ready;
   logic         o_core_reset;
   logic         o_core_aes_or_keccak;
   logic         o_core_enc_or_dec;
   logic [127:0] o_core_key;
   logic [511:0] o_core_data;
   logic [511:0] i_core_data;
   logic         i_core_done;
   logic         o_busy;
   logic         o_error;

   aesha_stream_ctrl #(
      .WORD_W         (32),
      .KEY_W          (128),
      .DATA_W         (512),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk                (clk),
      .i_reset              (i_reset),
      .i_in_data            (i_in_data),
      .i_in_valid           (i_in_valid),
      .o_in_ready           (o_in_ready),
      .o_out_data           (o_out_data),
      .o_out_valid          (o_out_valid),
      .i_out_ready          (i_out_ready),
      .o_core_reset         (o_core_reset),
      .o_core_aes_or_keccak (o_core_aes_or_keccak),
      .o_core_enc_or_dec    (o_core_enc_or_dec),
      .o_core_key           (o_core_key),
      .o_core_data          (o_core_data),
      .i_core_data          (i_core_data),
      .i_core_done          (i_core_done),
      .o_busy               (o_busy),
      .o_error              (o_error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int lat      = 10;
   bit stale    = 1'b0;
   bit never    = 1'b0;
   bit bpon     = 1'b0;
   int gapmax   = 0;
   int lowcnt   = 0;
   int last_run = 0;
   bit err_exp  = 1'b0;

   logic [31:0]  tb_kw [4];
   logic [31:0]  tb_dw [16];
   logic [127:0] model_key  = '0;
   logic [511:0] model_data = '0;

   // Core model: counts cycles with its reset released, optionally raises a
   // stale done in the first such cycle, completes after 'lat' more cycles
   // with result = block XOR A5A5A5A5 per word.
   always @(negedge clk) begin
      if (o_core_reset === 1'b0) begin
         lowcnt = lowcnt + 1;
      end else begin
         if (lowcnt != 0) last_run = lowcnt;
         lowcnt = 0;
      end
      i_core_done = 1'b0;
      i_core_data = '0;
      if (stale && lowcnt == 1) begin
         i_core_done = 1'b1;
         i_core_data = {16{32'hDEADBEEF}};
      end else if (!never && lowcnt == lat + 1) begin
         i_core_done = 1'b1;
         i_core_data = o_core_data ^ {16{32'hA5A5A5A5}};
      end
   end

   task automatic chk(input string tag,
                      input logic [511:0] obs,
                      input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] w);
      int gap;
      int t;
      gap = $urandom_range(gapmax, 0);
      repeat (gap) @(negedge clk);
      i_in_valid = 1'b1;
      i_in_data  = w;
      t = 0;
      while (o_in_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("in_ready_wait", o_in_ready, 1'b1);
      @(negedge clk);
      i_in_valid = 1'b0;
      i_in_data  = $urandom;
   endtask

   task automatic recv(input bit zero);
      int k;
      int cyc;
      bit stalled;
      logic [31:0] held;
      logic [31:0] exp;
      k = 0;
      cyc = 0;
      stalled = 1'b0;
      held = '0;
      while (k < 16 && cyc < 2000) begin
         i_out_ready = bpon ? 1'($urandom_range(1, 0)) : 1'b1;
         if (o_out_valid === 1'b1) begin
            if (stalled) chk("out_hold", o_out_data, held);
            if (i_out_ready) begin
               exp = zero ? 32'h0 : (tb_dw[k] ^ 32'hA5A5A5A5);
               chk($sformatf("out_word%0d", k), o_out_data, exp);
               k++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = o_out_data;
            end
         end
         @(negedge clk);
         cyc++;
      end
      i_out_ready = 1'b0;
      chk("out_count", k, 16);
      chk("valid_after", o_out_valid, 1'b0);
      chk("busy_after", o_busy, 1'b0);
   endtask

   task automatic rand_frame_data(input bit new_key);
      if (new_key)
         for (int i = 0; i < 4; i++) tb_kw[i] = $urandom;
      for (int i = 0; i < 16; i++) tb_dw[i] = $urandom;
   endtask

   task automatic frame(input logic [2:0] cmd, input bit bp,
                        input int gmax, input int l,
                        input bit st, input bit nev);
      logic [31:0] c;
      lat    = l;
      stale  = st;
      never  = nev;
      bpon   = bp;
      gapmax = gmax;
      c = $urandom;
      c[2:0] = cmd;
      send(c);
      if (!cmd[2]) begin
         model_key = '0;
         for (int i = 0; i < 4; i++) begin
            send(tb_kw[i]);
            model_key = model_key | ({96'h0, tb_kw[i]} << (32 * i));
         end
      end
      model_data = '0;
      for (int i = 0; i < 16; i++) begin
         send(tb_dw[i]);
         model_data = model_data | ({480'h0, tb_dw[i]} << (32 * i));
      end
      chk("launch_ready", o_in_ready, 1'b0);
      chk("launch_core_rst", o_core_reset, 1'b0);
      chk("launch_busy", o_busy, 1'b1);
      recv(nev);
      chk("core_rst_low", last_run, nev ? TMO + 1 : l + 1);
      chk("core_key", o_core_key, model_key);
      chk("core_data", o_core_data, model_data);
      chk("core_aes", o_core_aes_or_keccak, cmd[0]);
      chk("core_dir", o_core_enc_or_dec, cmd[1]);
      chk("error", o_error, err_exp);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_ready"}, o_in_ready, 1'b0);
      chk({tag, "_valid"}, o_out_valid, 1'b0);
      chk({tag, "_odata"}, o_out_data, 32'h0);
      chk({tag, "_core_rst"}, o_core_reset, 1'b1);
      chk({tag, "_aes"}, o_core_aes_or_keccak, 1'b0);
      chk({tag, "_dir"}, o_core_enc_or_dec, 1'b0);
      chk({tag, "_key"}, o_core_key, 128'h0);
      chk({tag, "_data"}, o_core_data, 512'h0);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_error"}, o_error, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      i_reset     = 1'b1;
      i_in_data   = '0;
      i_in_valid  = 1'b0;
      i_out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_checks("rst");
      i_reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", o_in_ready, 1'b1);

      // Encrypt frame with the fixed key and incrementing block.
      tb_kw[0] = 32'h03020100;
      tb_kw[1] = 32'h07060504;
      tb_kw[2] = 32'h0B0A0908;
      tb_kw[3] = 32'h0F0E0D0C;
      for (int i = 0; i < 16; i++) tb_dw[i] = 32'h1000_0000 + i;
      frame(3'h1, 1'b0, 0, 10, 1'b0, 1'b0);
      chk("key_literal", o_core_key,
          128'h0F0E0D0C_0B0A0908_07060504_03020100);

      // Key reuse.
      rand_frame_data(1'b0);
      frame(3'h5, 1'b0, 0, 10, 1'b0, 1'b0);

      // Backpressure and input gaps with a fresh key.
      rand_frame_data(1'b1);
      frame(3'h2, 1'b1, 3, $urandom_range(20, 1), 1'b0, 1'b0);
      rand_frame_data(1'b1);
      frame(3'h3, 1'b1, 2, $urandom_range(20, 1), 1'b0, 1'b0);

      // Stale done in the launch cycle.
      rand_frame_data(1'b0);
      frame(3'h7, 1'b1, 1, 5, 1'b1, 1'b0);

      // Reset in the middle of the block.
      rand_frame_data(1'b1);
      stale = 1'b0;
      gapmax = 1;
      send(32'h0000_0001);
      for (int i = 0; i < 4; i++) send(tb_kw[i]);
      for (int i = 0; i < 7; i++) send(tb_dw[i]);
      chk("mid_busy", o_busy, 1'b1);
      i_reset = 1'b1;
      #1;
      reset_checks("mid_rst");
      @(negedge clk);
      i_reset = 1'b0;
      @(negedge clk);
      model_key = '0;
      rand_frame_data(1'b1);
      frame(3'h0, 1'b1, 2, 7, 1'b0, 1'b0);

`ifdef AESHA_STREAM_TIMEOUT_EN
      // Core never completes: watchdog drains zeros and flags error.
      rand_frame_data(1'b0);
      err_exp = 1'b1;
      frame(3'h4, 1'b1, 1, 10, 1'b0, 1'b1);
      rand_frame_data(1'b1);
      frame(3'h1, 1'b0, 0, 3, 1'b0, 1'b0);
      i_reset = 1'b1;
      #1;
      chk("tmo_err_cleared", o_error, 1'b0);
      @(negedge clk);
      i_reset = 1'b0;
      err_exp = 1'b0;
      @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aesha_stream_ctrl.md
Name: aesha_stream_ctrl

Overview:
Host-side initiator for the AESHA accelerator top. It accepts a 32-bit valid/ready word stream carrying a command, a key and a data block, and assembles them into the 128-bit key and 512-bit block. It launches one AESHA operation, waits for completion, captures the 512-bit result and streams it back out as 32-bit words. It sits between the bus-facing FIFO/DMA and the accelerator top; the accelerator core is reset while idle and released to run.

Parameters:
WORD_W, 32, stream word width; must divide KEY_W and DATA_W.
KEY_W, 128, key width; gives KEY_WORDS = KEY_W/WORD_W = 4.
DATA_W, 512, block width; gives DATA_WORDS = DATA_W/WORD_W = 16.
TIMEOUT_CYCLES, 4096, watchdog limit; used only with AESHA_STREAM_TIMEOUT_EN.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_in_data  in  WORD_W  input stream word
i_in_valid  in  1  input word valid
o_in_ready  out  1  input word accepted when valid&ready
o_out_data  out  WORD_W  result stream word
o_out_valid  out  1  result word valid
i_out_ready  in  1  downstream accepts result word
o_core_reset  out  1  drives accelerator reset; high = held idle
o_core_aes_or_keccak  out  1  mode to accelerator
o_core_enc_or_dec  out  1  direction to accelerator
o_core_key  out  KEY_W  key to accelerator
o_core_data  out  DATA_W  block to accelerator
i_core_data  in  DATA_W  accelerator result
i_core_done  in  1  accelerator completion
o_busy  out  1  high whenever not in S_CMD
o_error  out  1  sticky timeout flag; constant 0 without the macro

Behaviour:
- Reset values: o_in_ready=0, o_out_valid=0, o_out_data=0, o_core_reset=1, mode bits=0, o_core_key=0, o_core_data=0, o_busy=0, o_error=0, state=S_CMD, word counter=0.
- In S_CMD, o_in_ready rises on the first cycle after reset is released.
- States: S_CMD, S_KEY, S_DATA, S_LAUNCH, S_WAIT, S_DRAIN.
- S_CMD: o_in_ready=1. On a handshake, latch the command word:
  - bit0 is aes_or_keccak; bit1 is enc_or_dec; bit2 is key_reuse.
  - key_reuse=1 goes to S_DATA and keeps the previous key register (0 after reset).
  - Otherwise go to S_KEY.
- S_KEY: o_in_ready=1. Accept KEY_WORDS words. Word n fills key bits [n*WORD_W +: WORD_W] (word 0 is the LSW). After the last word, go to S_DATA.
- S_DATA: same scheme for DATA_WORDS words into the block register. After the last word, go to S_LAUNCH.
- S_LAUNCH: exactly one cycle, o_in_ready=0. o_core_reset goes low from this cycle and stays low through S_WAIT. i_core_done is ignored in S_LAUNCH (stale-done guard).
- S_WAIT: on i_core_done=1:
  - capture i_core_data into the result register;
  - drive o_core_reset high on the next cycle;
  - go to S_DRAIN.
- S_DRAIN: o_out_valid=1 and o_out_data = result word k, LSW first. k advances on valid&ready. After word DATA_WORDS-1 is accepted, go to S_CMD. o_out_data holds stable while valid&!ready.
- Outside S_DRAIN, o_out_valid=0. Outside S_CMD, S_KEY and S_DATA, o_in_ready=0. Input words are never dropped or duplicated.
- o_core_* mode, key and data outputs are registered and stay stable from S_LAUNCH until the next command.
- i_core_done outside S_WAIT has no effect.
- Word counter is log2(DATA_WORDS) bits and clears on every state change.
- Minimum latency: last data word accepted to first o_out_valid = 2 cycles + core latency.
- i_reset mid-operation: the FSM returns to S_CMD asynchronously, all registers take their reset values and o_core_reset=1. A partial frame is discarded.

Optional Feature:
AESHA_STREAM_TIMEOUT_EN. With it defined:
- A cycle counter runs in S_WAIT.
- If TIMEOUT_CYCLES elapse without i_core_done: set o_error (sticky until i_reset), raise o_core_reset, and go to S_DRAIN with an all-zero result so the host frame still completes.
- Done and timeout in the same cycle: done wins.

Without the macro: no counter, o_error tied 0, S_WAIT waits indefinitely.

Decomposition:
- Shared package aesha_pkg holds:
  - the state enum;
  - command bit-position constants CMD_MODE_BIT=0, CMD_DIR_BIT=1, CMD_REUSE_BIT=2;
  - derived KEY_WORDS and DATA_WORDS localparams.
- One natural sub-module: aesha_word_pack, a parameterised shift-in word assembler with a counter and a last-word flag. It is instantiated for both key and data.
- Drain uses an index mux and needs no sub-module.

Test Plan:
- Encrypt frame: cmd 0x1, key words 0x03020100..0x0F0E0D0C, data = 16 incrementing words; core model asserts done after 10 cycles with result = data XOR 0xA5A5A5A5 per word. Required: core_key=0x0F0E..0100, o_core_reset low for exactly 11 cycles, 16 output words in LSW order, o_busy low after the last word.
- Key reuse: second frame with cmd 0x5 and 16 data words. Required: no key words consumed, o_core_key unchanged, o_core_enc_or_dec=0, o_core_aes_or_keccak=1.
- Backpressure: toggle i_out_ready randomly 50%. Required: o_out_data stable while stalled, exactly 16 distinct words delivered; random i_in_valid gaps produce a correct assembly.
- Stale done: hold i_core_done=1 during S_LAUNCH, model done 5 cycles later. Required: capture occurs only in S_WAIT.
- Reset mid-S_DATA after 7 words. Required: all outputs return to reset values immediately; a subsequent full frame is correct.
- With AESHA_STREAM_TIMEOUT_EN and TIMEOUT_CYCLES=64, core never completes. Required: o_error=1 after 64 wait cycles, 16 zero words out, o_error stays 1 until i_reset.
